mc14500_core: RTL
=================

# mc14500_core

Parametrised, single-clock successor to the MC14500B processor top. It integrates program memory with a halted-only load port, a program counter with a bounded call/return stack, and a 1-bit ICU with IEN/OEN gating. It adds a memory-mapped scratch bit RAM and run/step/halt control with error reporting. It replaces the handshake-chained top with a fixed 2-cycle FETCH/EXEC sequencer, for integration under a host controller.

## Interface

- ADDR_WIDTH, 8, width of the program-counter, operand and I/O address fields
- INSTRUCTION_WIDTH, 4, opcode field width; opcode occupies the top bits of each program word
- DATA_WIDTH, ADDR_WIDTH+INSTRUCTION_WIDTH, program word width
- STACK_DEPTH, 16, return-stack entries (≥1)
- INPUT_SIZE, 8, input pins mapped at addresses 0..INPUT_SIZE-1 (read)
- OUTPUT_SIZE, 8, output pins mapped at addresses 0..OUTPUT_SIZE-1 (write)
- SCRATCH_BASE, 128, first scratch-bit address
- SCRATCH_SIZE, 16, scratch bits (read/write) at SCRATCH_BASE..SCRATCH_BASE+SCRATCH_SIZE-1

Ports:

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- run  in  1  level; 1 = free-run, 0 = halt after the current instruction
- step  in  1  one-cycle pulse; in HALT, executes exactly one instruction
- prog_we  in  1  program write strobe, honoured only in HALT
- prog_addr  in  ADDR_WIDTH  program write address
- prog_data  in  DATA_WIDTH  program write data
- input_pins  in  INPUT_SIZE  sampled in EXEC
- output_pins  out  OUTPUT_SIZE  registered outputs, reset 0
- pc  out  ADDR_WIDTH  current program counter, reset 0
- rr  out  1  result register, reset 0
- halted  out  1  1 in HALT state, reset 1
- flag_o  out  1  one-cycle pulse on NOPO execution, reset 0
- flag_f  out  1  one-cycle pulse on NOPF execution, reset 0
- error  out  1  sticky; stack overflow/underflow; cleared only by reset

## Operation

- Opcodes:
  - 0 NOPO
  - 1 LD
  - 2 LDC
  - 3 AND
  - 4 ANDC
  - 5 OR
  - 6 ORC
  - 7 XNOR
  - 8 STO
  - 9 STOC
  - A IEN
  - B OEN
  - C JMP
  - D RTN
  - E SKZ
  - F NOPF
- Operand a = word[ADDR_WIDTH-1:0].
- Read data d:
  - a == all-ones → RR;
  - a < INPUT_SIZE → input_pins[a];
  - a in scratch range → scratch[a-SCRATCH_BASE];
  - else 0.
- If IEN=0, d is forced to 0 for LD/LDC/AND/ANDC/OR/ORC/XNOR. It is not forced for IEN/OEN, which load d raw.
- ALU: LD RR=d; LDC RR=~d; AND RR&=d; ANDC RR&=~d; OR RR|=d; ORC RR|=~d; XNOR RR=~(RR^d).
- STO writes RR and STOC writes ~RR to the target, only when OEN=1:
  - a < OUTPUT_SIZE → output_pins[a];
  - scratch range → scratch bit;
  - a == all-ones → RR;
  - else the write is dropped.
- IEN/OEN reset to 1.
- JMP:
  - push pc+1 (mod 2^ADDR_WIDTH), pc=a;
  - if the stack already holds STACK_DEPTH entries: no push, no jump, error=1, go to HALT.
- RTN:
  - pop into pc, then skip one instruction (pc = popped+1);
  - on an empty stack: error=1, go to HALT, pc unchanged.
- SKZ: if RR==0, pc+=2, else pc+=1.
- All other opcodes: pc+=1. The PC wraps from all-ones to 0.
- States:
  - HALT: load port active. Leaves to FETCH when run=1 and error=0, or when a step pulse arrives with error=0 (single-step latched).
  - FETCH: synchronous program read at pc → EXEC.
  - EXEC: execute the latched word. Next state:
    - HALT if error was raised, or if single-step was latched, or if run=0;
    - else FETCH.
- prog_we outside HALT is ignored. The program memory is not cleared by reset.

## Timing

- Each instruction takes 2 cycles (FETCH, EXEC). All architectural updates (pc, RR, IEN, OEN, outputs, scratch, stack, flags) occur at the EXEC→next edge.
- flag_o/flag_f are high for exactly the cycle after NOPO/NOPF EXEC.
- Reset in any state, mid-instruction included, immediately causes:
  - state=HALT;
  - pc=0, RR=0, IEN=OEN=1;
  - outputs, scratch and stack pointer cleared;
  - error=0, flags 0.
- run deasserted during FETCH: the fetched instruction still completes, and halted rises the cycle after EXEC.
- A step pulse in FETCH/EXEC is ignored. A step asserted together with run=1 in HALT behaves as run.
- A program write to address pc in HALT takes effect on the next FETCH.
- halted is asserted while in HALT, including the first cycle after reset.

## Test plan

- Load program {LD 0, STO 0, JMP 0} with input_pins[0]=1 and run=1 → output_pins[0]=1 after 4 cycles; pc cycles 0,1,2,0.
- IEN gating: {IEN with a selecting a 0 input, LD 1} with input_pins[1]=1 → RR=0. Repeat with the IEN source=1 → RR=1.
- OEN=0 then STO 3 with RR=1 → output_pins[3] stays 0. Scratch: STO SCRATCH_BASE+2 with RR=1, then LDC SCRATCH_BASE+2 → RR=0.
- Stack: STACK_DEPTH+1 nested JMPs → error=1, halted=1, pc held at the failing JMP. RTN on an empty stack after reset → error=1.
- SKZ with RR=0 at pc=5 → next pc=7. RTN after JMP from pc=3 → pc=5.
- Step mode: run=0, step pulse → exactly one instruction executes, halted returns after 2 cycles. Reset asserted during EXEC of STO → output_pins stays 0, pc=0.

Source files
------------

// File: rtl/mc14500_core_if.sv
// mc14500_core_if: program-load port between a host controller and the core.
//   prog_we   - write strobe (the core honours it only while halted)
//   prog_addr - program word address
//   prog_data - program word ({opcode, operand})
// master = host side, slave = core side.
interface mc14500_core_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 12
);
    logic                  prog_we;
    logic [ADDR_WIDTH-1:0] prog_addr;
    logic [DATA_WIDTH-1:0] prog_data;
    modport master (output prog_we, prog_addr, prog_data);
    modport slave  (input  prog_we, prog_addr, prog_data);
endinterface

// File: rtl/mc14500_core.sv
// mc14500_core: 1-bit MC14500-style processor with a FETCH/EXEC sequencer.
//   clk, reset              - clock, synchronous active-high reset
//   run, step               - free-run level / single-step pulse (honoured in HALT)
//   prog                    - program-load port (slave), written only while halted
//   input_pins, output_pins - bit I/O mapped at low addresses
//   pc, rr                  - program counter and result register
//   halted, flag_o, flag_f  - HALT state, NOPO/NOPF one-cycle pulses
//   error                   - sticky stack overflow/underflow
module mc14500_core #(
    parameter int ADDR_WIDTH        = 8,
    parameter int INSTRUCTION_WIDTH = 4,
    parameter int DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH,
    parameter int STACK_DEPTH       = 16,
    parameter int INPUT_SIZE        = 8,
    parameter int OUTPUT_SIZE       = 8,
    parameter int SCRATCH_BASE      = 128,
    parameter int SCRATCH_SIZE      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   step,
    mc14500_core_if.slave          prog,
    input  logic [INPUT_SIZE-1:0]  input_pins,
    output logic [OUTPUT_SIZE-1:0] output_pins,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   rr,
    output logic                   halted,
    output logic                   flag_o,
    output logic                   flag_f,
    output logic                   error
);
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    typedef enum logic [1:0] {HALT, FETCH, EXEC} state_t;
    state_t                  state;
    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0]   ir;
    logic [ADDR_WIDTH-1:0]   stk [STACK_DEPTH];
    logic [SPW-1:0]          sp;
    logic [SCRATCH_SIZE-1:0] scratch;
    logic                    ien, oen, single;
    logic [INSTRUCTION_WIDTH-1:0] op;
    logic [ADDR_WIDTH-1:0]   a, top, pc_n;
    int                      ai;
    logic                    d, dg, wv, in_scr, rr_n, ien_n, oen_n, push, fault;
    logic [OUTPUT_SIZE-1:0]  out_n;
    logic [SCRATCH_SIZE-1:0] scr_n;
    logic [SPW-1:0]          sp_n;

    assign op = ir[DATA_WIDTH-1 -: INSTRUCTION_WIDTH];
    assign a  = ir[ADDR_WIDTH-1:0];
    assign ai = int'(a);

    always_ff @(posedge clk) begin
        if (state == HALT && prog.prog_we) mem[prog.prog_addr] <= prog.prog_data;
        if (state == FETCH) ir <= mem[pc];
    end

    always_comb begin
        in_scr = ai >= SCRATCH_BASE && ai < SCRATCH_BASE + SCRATCH_SIZE;
        // Later assignments win: all-ones (RR) beats inputs, inputs beat scratch.
        d = 1'b0;
        for (int i = 0; i < SCRATCH_SIZE; i++) if (ai == SCRATCH_BASE + i) d = scratch[i];
        for (int i = 0; i < INPUT_SIZE; i++) if (ai == i) d = input_pins[i];
        if (&a) d = rr;
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) if (int'(sp) == i + 1) top = stk[i];
        dg    = d & ien;
        wv    = (int'(op) == 9) ? ~rr : rr;
        rr_n  = rr;
        ien_n = ien;
        oen_n = oen;
        out_n = output_pins;
        scr_n = scratch;
        sp_n  = sp;
        push  = 1'b0;
        fault = 1'b0;
        pc_n  = pc + ADDR_WIDTH'(1);
        case (int'(op))
            1: rr_n = dg;
            2: rr_n = ~dg;
            3: rr_n = rr & dg;
            4: rr_n = rr & ~dg;
            5: rr_n = rr | dg;
            6: rr_n = rr | ~dg;
            7: rr_n = ~(rr ^ dg);
            8, 9: if (oen) begin
                for (int i = 0; i < OUTPUT_SIZE; i++) if (ai == i) out_n[i] = wv;
                for (int i = 0; i < SCRATCH_SIZE; i++)
                    if (ai >= OUTPUT_SIZE && ai == SCRATCH_BASE + i) scr_n[i] = wv;
                if (&a && ai >= OUTPUT_SIZE && !in_scr) rr_n = wv;
            end
            10: ien_n = d;
            11: oen_n = d;
            12: if (int'(sp) == STACK_DEPTH) begin
                fault = 1'b1;
                pc_n  = pc;
            end else begin
                push = 1'b1;
                sp_n = sp + SPW'(1);
                pc_n = a;
            end
            // Return lands one past the pushed address, skipping the word after the call.
            13: if (sp == '0) begin
                fault = 1'b1;
                pc_n  = pc;
            end else begin
                sp_n = sp - SPW'(1);
                pc_n = top + ADDR_WIDTH'(1);
            end
            14: pc_n = pc + ADDR_WIDTH'(rr ? 1 : 2);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HALT;
            halted      <= 1'b1;
            single      <= 1'b0;
            pc          <= '0;
            rr          <= 1'b0;
            ien         <= 1'b1;
            oen         <= 1'b1;
            output_pins <= '0;
            scratch     <= '0;
            sp          <= '0;
            error       <= 1'b0;
            flag_o      <= 1'b0;
            flag_f      <= 1'b0;
        end else begin
            flag_o <= state == EXEC && int'(op) == 0;
            flag_f <= state == EXEC && int'(op) == 15;
            case (state)
                HALT: if (!error && (run || step)) begin
                    state  <= FETCH;
                    halted <= 1'b0;
                    single <= !run;
                end
                FETCH: state <= EXEC;
                EXEC: begin
                    pc          <= pc_n;
                    rr          <= rr_n;
                    ien         <= ien_n;
                    oen         <= oen_n;
                    output_pins <= out_n;
                    scratch     <= scr_n;
                    sp          <= sp_n;
                    error       <= error | fault;
                    for (int i = 0; i < STACK_DEPTH; i++)
                        if (push && int'(sp) == i) stk[i] <= pc + ADDR_WIDTH'(1);
                    if (fault || single || !run) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state  <= HALT;
                    halted <= 1'b1;
                end
            endcase
        end
    end
endmodule
